// File: rtl/kb_pkg.sv
// Shared constants for the scan-code set 2 decoder.
// Covers byte codes, held-bit indices, FSM encoding and the control key map.
package kb_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    // Extended (E0) arrow keys
    localparam logic [7:0] KC_E_LEFT  = 8'h6B;
    localparam logic [7:0] KC_E_RIGHT = 8'h74;
    localparam logic [7:0] KC_E_UP    = 8'h75;
    localparam logic [7:0] KC_E_DOWN  = 8'h72;
    // Plain WASD and space
    localparam logic [7:0] KC_A       = 8'h1C;
    localparam logic [7:0] KC_D       = 8'h23;
    localparam logic [7:0] KC_W       = 8'h1D;
    localparam logic [7:0] KC_S       = 8'h1B;
    localparam logic [7:0] KC_SPACE   = 8'h29;

    localparam int HELD_LEFT  = 0;
    localparam int HELD_RIGHT = 1;
    localparam int HELD_UP    = 2;
    localparam int HELD_DOWN  = 3;
    localparam int HELD_FIRE  = 4;
    localparam int HELD_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kb_state_t;

    // One-hot held mask for a decoded key; zero for unmapped keys.
    function automatic logic [HELD_W-1:0] key_mask(input logic ext, input logic [7:0] code);
        logic [HELD_W-1:0] m;
        m = '0;
        case ({ext, code})
            {1'b1, KC_E_LEFT},  {1'b0, KC_A}: m[HELD_LEFT]  = 1'b1;
            {1'b1, KC_E_RIGHT}, {1'b0, KC_D}: m[HELD_RIGHT] = 1'b1;
            {1'b1, KC_E_UP},    {1'b0, KC_W}: m[HELD_UP]    = 1'b1;
            {1'b1, KC_E_DOWN},  {1'b0, KC_S}: m[HELD_DOWN]  = 1'b1;
            {1'b0, KC_SPACE}:                 m[HELD_FIRE]  = 1'b1;
            default:                          m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/kb_timeout_ctr.sv
// Inter-byte timeout: counts while enabled, pulses expire on the last cycle.
// Latency: expire is combinational from the count; no backpressure.
// Clear wins over expire; the count restarts whenever disabled.
module kb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int CNT_W          = 22
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    assign expire = enable && !clear && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || !enable || expire) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/kb_scancode_decoder.sv
// Scan-code set 2 sequence decoder with game-control held flags (KB_TYPEMATIC_FILTER_EN drops repeats).
// Latency: key event, held and fire_pulse register one cycle after the final byte strobe.
// No backpressure: every rx_done_tick byte is consumed in the cycle it arrives.
module kb_scancode_decoder
    import kb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int CNT_W          = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_done_tick,
    output logic [7:0]        key_code,
    output logic              key_ext,
    output logic              key_break,
    output logic              key_valid,
    output logic [HELD_W-1:0] held,
    output logic              fire_pulse
);

    kb_state_t         state_q, state_d;
    logic              expire;
    logic              ev, ev_ext, ev_brk, clr_held;
    logic              report;
    logic [HELD_W-1:0] mask, held_next;

    kb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (rx_done_tick),
        .enable (state_q != ST_IDLE),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A strobe in the expiry cycle is decoded in the old state.
    always_comb begin
        state_d  = state_q;
        ev       = 1'b0;
        ev_ext   = 1'b0;
        ev_brk   = 1'b0;
        clr_held = 1'b0;
        if (rx_done_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (rx_data == SC_BRK) begin
                        state_d = ST_BRK;
                    end else if (rx_data == SC_BAT) begin
                        clr_held = 1'b1;
                    end else if (rx_data == SC_PAUSE || rx_data == SC_ACK || rx_data == SC_ECHO ||
                                 rx_data == SC_RESEND || rx_data == SC_ERR0 || rx_data == SC_ERR1) begin
                        state_d = ST_IDLE;
                    end else begin
                        ev = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (rx_data == SC_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (rx_data != SC_EXT) begin
                        ev      = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                    if (rx_data != SC_EXT && rx_data != SC_BRK) begin
                        ev     = 1'b1;
                        ev_brk = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    if (rx_data != SC_EXT && rx_data != SC_BRK) begin
                        ev     = 1'b1;
                        ev_ext = 1'b1;
                        ev_brk = 1'b1;
                    end
                end
            endcase
        end else if (expire) begin
            state_d = ST_IDLE;
        end
    end

    assign mask      = key_mask(ev_ext, rx_data);
    assign held_next = ev_brk ? (held & ~mask) : (held | mask);

`ifdef KB_TYPEMATIC_FILTER_EN
    // A make for a key already held is a typematic repeat.
    assign report = ev && !(!ev_brk && |(mask & held));
`else
    assign report = ev;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            key_code   <= '0;
            key_ext    <= 1'b0;
            key_break  <= 1'b0;
            key_valid  <= 1'b0;
            held       <= '0;
            fire_pulse <= 1'b0;
        end else begin
            key_valid  <= report;
            fire_pulse <= report && !ev_brk && mask[HELD_FIRE];
            if (report) begin
                key_code  <= rx_data;
                key_ext   <= ev_ext;
                key_break <= ev_brk;
            end
            if (clr_held) begin
                held <= '0;
            end else if (ev) begin
                held <= held_next;
            end
        end
    end

endmodule

// File: tb/tb_kb_scancode_decoder.sv
// Scoreboarded bench for kb_scancode_decoder: directed byte sequences with hand-computed events.
// A negedge monitor pops expected events whenever key_valid is seen and checks latency.
module tb_kb_scancode_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done_tick = 1'b0;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_valid;
    logic [4:0] held;
    logic       fire_pulse;

    kb_scancode_decoder #(
        .TIMEOUT_CYCLES (100),
        .CNT_W          (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_break    (key_break),
        .key_valid    (key_valid),
        .held         (held),
        .fire_pulse   (fire_pulse)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [4:0] hld;
        logic       fp;
        int         at;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (key_valid) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: got code=%h ext=%b brk=%b at cycle %0d, required no event",
                             key_code, key_ext, key_break, cyc);
                end else begin
                    e = sbq.pop_front();
                    if (key_code !== e.code || key_ext !== e.ext || key_break !== e.brk ||
                        held !== e.hld || fire_pulse !== e.fp || cyc != e.at) begin
                        n_bad++;
                        $display("FAIL event: got code=%h ext=%b brk=%b held=%b fp=%b cyc=%0d, required code=%h ext=%b brk=%b held=%b fp=%b cyc=%0d",
                                 key_code, key_ext, key_break, held, fire_pulse, cyc,
                                 e.code, e.ext, e.brk, e.hld, e.fp, e.at);
                    end
                end
            end else if (fire_pulse) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stray_fire_pulse: got fire_pulse=1 without key_valid at cycle %0d, required 0", cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic has_ev, input logic ext, input logic brk,
                        input logic [4:0] h, input logic fp);
        exp_t e;
        @(negedge clk);
        if (has_ev) begin
            e.code = b; e.ext = ext; e.brk = brk; e.hld = h; e.fp = fp; e.at = cyc + 1;
            sbq.push_back(e);
        end
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        idle(3);
    endtask

    task automatic pre(input logic [7:0] b);
        send(b, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0);
    endtask

    task automatic check_held(input string name, input logic [4:0] h);
        n_cmp++;
        if (held !== h) begin
            n_bad++;
            $display("FAIL %s: got held=%b, required %b", name, held, h);
        end
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if ({key_code, key_ext, key_break, key_valid, held, fire_pulse} !== 17'd0) begin
            n_bad++;
            $display("FAIL %s: got code=%h ext=%b brk=%b vld=%b held=%b fp=%b, required all 0",
                     name, key_code, key_ext, key_break, key_valid, held, fire_pulse);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        check_zero("reset_state");
        reset = 1'b0;
        idle(2);

        // Space make then break
        send(8'h29, 1, 0, 0, 5'b10000, 1);
        idle(200);
        pre(8'hF0);
        send(8'h29, 1, 0, 1, 5'b00000, 0);

        // Extended left make/break, plus a doubled E0
        pre(8'hE0);
        send(8'h6B, 1, 1, 0, 5'b00001, 0);
        pre(8'hE0);
        pre(8'hF0);
        send(8'h6B, 1, 1, 1, 5'b00000, 0);
        pre(8'hE0);
        pre(8'hE0);
        send(8'h75, 1, 1, 0, 5'b00100, 0);
        pre(8'hE0);
        pre(8'hF0);
        send(8'h75, 1, 1, 1, 5'b00000, 0);

        // Abandoned E0, then plain A
        pre(8'hE0);
        idle(150);
        send(8'h1C, 1, 0, 0, 5'b00001, 0);
        pre(8'hF0);
        send(8'h1C, 1, 0, 1, 5'b00000, 0);

        // Abandoned F0, then space is a make
        pre(8'hF0);
        idle(150);
        send(8'h29, 1, 0, 0, 5'b10000, 1);
        pre(8'hF0);
        send(8'h29, 1, 0, 1, 5'b00000, 0);

        // Malformed F0 E0, ignored bytes, then S make/break
        pre(8'hF0);
        pre(8'hE0);
        pre(8'hFA);
        pre(8'hE1);
        pre(8'hFF);
        send(8'h1B, 1, 0, 0, 5'b01000, 0);
        pre(8'hF0);
        send(8'h1B, 1, 0, 1, 5'b00000, 0);

        // W, D, then BAT clears held
        send(8'h1D, 1, 0, 0, 5'b00100, 0);
        send(8'h23, 1, 0, 0, 5'b00110, 0);
        check_held("held_wd", 5'b00110);
        pre(8'hAA);
        check_held("held_after_bat", 5'b00000);

        // Reset between prefix and final byte
        pre(8'hE0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_zero("mid_seq_reset");
        send(8'h74, 1, 0, 0, 5'b00000, 0);
        check_held("held_after_74", 5'b00000);

        // Typematic space repeats
        send(8'h29, 1, 0, 0, 5'b10000, 1);
        idle(100);
`ifdef KB_TYPEMATIC_FILTER_EN
        pre(8'h29);
        idle(100);
        pre(8'h29);
`else
        send(8'h29, 1, 0, 0, 5'b10000, 1);
        idle(100);
        send(8'h29, 1, 0, 0, 5'b10000, 1);
`endif
        idle(100);
        pre(8'hF0);
        send(8'h29, 1, 0, 1, 5'b00000, 0);

        idle(20);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL missing_events: got %0d events still pending, required 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
